stream_fifo_sync: RTL and testbench
===================================

STREAM_FIFO_SYNC -- requirements
Module: stream_fifo_sync

Interface
REQ-001 SHALL have parameter FALL_THROUGH, default 0: 1 lets data written into an empty FIFO appear at the output in the same cycle.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: entry width in bits.
REQ-003 SHALL have parameter DEPTH, default 8: number of entries; 0 selects pass-through mode.
REQ-004 SHALL have a derived constant ADDR_DEPTH = (DEPTH>1) ? clog2(DEPTH) : 1.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port flush_i, input, 1 bit: synchronous clear of all contents.
REQ-008 SHALL have port testmode_i, input, 1 bit: DFT hook with no functional effect.
REQ-009 SHALL have port data_i, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port valid_i, input, 1 bit: write request.
REQ-011 SHALL have port ready_o, output, 1 bit: space available, equal to ~full_o.
REQ-012 SHALL have port data_o, output, DATA_WIDTH bits: head-of-queue data.
REQ-013 SHALL have port valid_o, output, 1 bit: data available, equal to ~empty_o.
REQ-014 SHALL have port ready_i, input, 1 bit: read acknowledge.
REQ-015 SHALL have port full_o, output, 1 bit: full status.
REQ-016 SHALL have port empty_o, output, 1 bit: empty status.
REQ-017 SHALL have port usage_o, output, ADDR_DEPTH bits: occupied entries.

Function
REQ-018 Push SHALL be valid_i & ready_o; pop SHALL be ready_i & valid_o; a push when full and a pop when empty SHALL be ignored with no state change.
REQ-019 Order SHALL be strict FIFO; data_o SHALL show the entry at the read pointer.
REQ-020 full_o SHALL assert when count == DEPTH; empty_o SHALL assert when count == 0, except as modified by REQ-022.
REQ-021 Simultaneous push and pop with the FIFO non-empty SHALL leave the count unchanged and advance both pointers; this SHALL also apply when the FIFO is full, because pop makes room in the same cycle.
REQ-022 FALL_THROUGH=1 with count 0 and push: empty_o SHALL be 0 and data_o = data_i in the same cycle.
REQ-023 In the REQ-022 case, if pop is also asserted, nothing SHALL be stored and the count SHALL remain 0.
REQ-024 FALL_THROUGH=0: written data SHALL become visible on the cycle after the push (1-cycle latency).
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-026 usage_o SHALL equal count[ADDR_DEPTH-1:0]; for a power-of-two DEPTH it reads 0 when full, and full_o disambiguates.
REQ-027 flush_i SHALL zero the pointers and count at the next edge and SHALL override a simultaneous push or pop.
REQ-028 DEPTH=0 SHALL give pass-through mode: data_o = data_i, valid_o = valid_i, ready_o = ready_i, with no storage.
REQ-029 Storage contents outside the valid region SHALL be don't-care; data_o SHALL be don't-care while empty_o=1.

Reset
REQ-030 rst_i=1 at a clock edge SHALL clear the read pointer, write pointer and count, giving empty_o=1, full_o=0 (for DEPTH>0), usage_o=0, valid_o=0 and ready_o=1.
REQ-031 Reset SHALL dominate flush_i, push and pop.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries.
REQ-033 Storage SHALL not require reset.

Structure
REQ-034 No shared package SHALL be needed; ADDR_DEPTH SHALL be a local constant.
REQ-035 The design SHALL contain one sub-module, fifo_core_sync, providing push_i/pop_i/full_o/empty_o/usage_o plus the storage.
REQ-036 The top level SHALL only map valid/ready onto fifo_core_sync and generate the pass-through case.

Verification
REQ-037 DEPTH=4, FALL_THROUGH=0: push 0xA, 0xB, 0xC, 0xD on consecutive cycles -> full_o=1, ready_o=0, usage_o=0; then pop 4 times -> data_o reads A, B, C, D, after which empty_o=1.
REQ-038 DEPTH=4, FALL_THROUGH=1, FIFO empty: valid_i=1, data_i=0x55, ready_i=1 -> valid_o=1 and data_o=0x55 in the same cycle, with the count still 0 afterwards.
REQ-039 DEPTH=3, FIFO full: push and pop together -> accepted, count stays 3; running 10 entries through the FIFO with wrap-around -> order preserved.
REQ-040 FIFO holding 2 entries: flush_i=1 together with valid_i=1 -> empty_o=1 and usage_o=0 on the next cycle.
REQ-041 rst_i=1 while the FIFO holds 3 entries -> next cycle valid_o=0 and ready_o=1; a pop while empty -> no change.
REQ-042 DEPTH=0: data_i=0x12, valid_i=1, ready_i=0 -> data_o=0x12, valid_o=1, ready_o=0.

Source files
------------

// File: rtl/fifo_core_sync.sv
// Synchronous FIFO core: storage, wrapping pointers and occupancy counter,
// with optional fall-through of a write into an empty queue.
module fifo_core_sync #(
    parameter  int unsigned FALL_THROUGH = 0,
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned DEPTH        = 8,
    localparam int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o
);

    localparam int unsigned            CNT_W     = ADDR_DEPTH + 1;
    localparam logic [ADDR_DEPTH-1:0]  LAST_PTR  = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]       DEPTH_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_DEPTH-1:0] r_rd_ptr;
    logic [ADDR_DEPTH-1:0] r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    logic w_full;
    logic w_empty_q;
    logic w_bypass;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_store;
    logic w_take;
    logic w_unused;

    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + ADDR_DEPTH'(1);
    endfunction

    assign w_unused  = testmode_i;

    assign w_full    = (r_count == DEPTH_CNT);
    assign w_empty_q = (r_count == '0);
    assign w_bypass  = (FALL_THROUGH != 0) && w_empty_q && push_i;
    assign w_empty   = w_empty_q && !w_bypass;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write then.
    assign w_pop     = pop_i && !w_empty;
    assign w_push    = push_i && (!w_full || w_pop);

    // A bypassed word that is popped immediately never enters storage.
    assign w_store   = w_push && !(w_bypass && w_pop);
    assign w_take    = w_pop && !w_empty_q;

    assign data_o    = w_bypass ? data_i : r_mem[r_rd_ptr];
    assign full_o    = w_full;
    assign empty_o   = w_empty;
    assign usage_o   = r_count[ADDR_DEPTH-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_take) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_store, w_take})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/stream_fifo_sync.sv
// Valid/ready stream FIFO: maps the handshake onto fifo_core_sync, or wires
// straight through when DEPTH is 0.
module stream_fifo_sync #(
    parameter  int unsigned FALL_THROUGH = 0,
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned DEPTH        = 8,
    localparam int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o
);

    generate
        if (DEPTH == 0) begin : g_passthrough
            logic w_unused;
            assign w_unused = clk_i ^ rst_i ^ flush_i ^ testmode_i;

            assign data_o   = data_i;
            assign valid_o  = valid_i;
            assign ready_o  = ready_i;
            assign full_o   = ~ready_i;
            assign empty_o  = ~valid_i;
            assign usage_o  = '0;
        end else begin : g_fifo
            logic w_full;
            logic w_empty;

            // The core gates push/pop against its own full/empty state.
            fifo_core_sync #(
                .FALL_THROUGH (FALL_THROUGH),
                .DATA_WIDTH   (DATA_WIDTH),
                .DEPTH        (DEPTH)
            ) u_core (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .flush_i    (flush_i),
                .testmode_i (testmode_i),
                .data_i     (data_i),
                .push_i     (valid_i),
                .pop_i      (ready_i),
                .data_o     (data_o),
                .full_o     (w_full),
                .empty_o    (w_empty),
                .usage_o    (usage_o)
            );

            assign full_o  = w_full;
            assign empty_o = w_empty;
            assign ready_o = ~w_full;
            assign valid_o = ~w_empty;
        end
    endgenerate

endmodule

// File: tb/tb_stream_fifo_sync.sv
// Bench for stream_fifo_sync: directed scenarios plus randomized traffic
// checked against queue-based reference models.
module tb_stream_fifo_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic tm = 1'b0;
    int checks = 0;
    int errors = 0;

    // A: DEPTH=4, FALL_THROUGH=0
    logic       a_rst = 1'b1, a_flush = 1'b0, a_valid_i = 1'b0, a_ready_i = 1'b0;
    logic [7:0] a_data_i = '0, a_data_o;
    logic       a_valid_o, a_ready_o, a_full, a_empty;
    logic [1:0] a_usage;
    // B: DEPTH=4, FALL_THROUGH=1
    logic       b_rst = 1'b1, b_flush = 1'b0, b_valid_i = 1'b0, b_ready_i = 1'b0;
    logic [7:0] b_data_i = '0, b_data_o;
    logic       b_valid_o, b_ready_o, b_full, b_empty;
    logic [1:0] b_usage;
    // C: DEPTH=3, FALL_THROUGH=0
    logic       c_rst = 1'b1, c_flush = 1'b0, c_valid_i = 1'b0, c_ready_i = 1'b0;
    logic [7:0] c_data_i = '0, c_data_o;
    logic       c_valid_o, c_ready_o, c_full, c_empty;
    logic [1:0] c_usage;
    // Z: DEPTH=0 pass-through
    logic       z_rst = 1'b1, z_flush = 1'b0, z_valid_i = 1'b0, z_ready_i = 1'b0;
    logic [7:0] z_data_i = '0, z_data_o;
    logic       z_valid_o, z_ready_o, z_full, z_empty;
    logic [0:0] z_usage;

    stream_fifo_sync #(.FALL_THROUGH(0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
        .clk_i(clk), .rst_i(a_rst), .flush_i(a_flush), .testmode_i(tm),
        .data_i(a_data_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
        .data_o(a_data_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
        .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage));

    stream_fifo_sync #(.FALL_THROUGH(1), .DATA_WIDTH(8), .DEPTH(4)) u_b (
        .clk_i(clk), .rst_i(b_rst), .flush_i(b_flush), .testmode_i(tm),
        .data_i(b_data_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
        .data_o(b_data_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage));

    stream_fifo_sync #(.FALL_THROUGH(0), .DATA_WIDTH(8), .DEPTH(3)) u_c (
        .clk_i(clk), .rst_i(c_rst), .flush_i(c_flush), .testmode_i(tm),
        .data_i(c_data_i), .valid_i(c_valid_i), .ready_o(c_ready_o),
        .data_o(c_data_o), .valid_o(c_valid_o), .ready_i(c_ready_i),
        .full_o(c_full), .empty_o(c_empty), .usage_o(c_usage));

    stream_fifo_sync #(.FALL_THROUGH(0), .DATA_WIDTH(8), .DEPTH(0)) u_z (
        .clk_i(clk), .rst_i(z_rst), .flush_i(z_flush), .testmode_i(tm),
        .data_i(z_data_i), .valid_i(z_valid_i), .ready_o(z_ready_o),
        .data_o(z_data_o), .valid_o(z_valid_o), .ready_i(z_ready_i),
        .full_o(z_full), .empty_o(z_empty), .usage_o(z_usage));

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        a_valid_i = 1'b1; a_ready_i = 1'b1; a_flush = 1'b1;
        repeat (2) @(negedge clk);
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; z_rst = 1'b0;
        a_valid_i = 1'b0; a_ready_i = 1'b0; a_flush = 1'b0;
        #1;
        checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %b exp 0", a_valid_o); end
        checks++; if (a_ready_o !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", a_ready_o); end
        checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_a_full got %b exp 0", a_full); end
        checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_a_empty got %b exp 1", a_empty); end
        checks++; if (a_usage !== 2'd0) begin errors++; $display("FAIL reset_a_usage got %0d exp 0", a_usage); end
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL reset_b_empty got %b exp 1", b_empty); end
        checks++; if (c_empty !== 1'b1 || c_ready_o !== 1'b1) begin errors++; $display("FAIL reset_c got empty=%b ready=%b exp 1 1", c_empty, c_ready_o); end
    endtask

    task automatic test_fill_drain();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a_valid_i = 1'b1; a_data_i = 8'h0A + 8'(i);
            #1;
            if (i == 0) begin
                checks++; if (a_valid_o !== 1'b0) begin errors++; $display("FAIL fill_same_cycle_valid got %b exp 0", a_valid_o); end
            end else begin
                checks++; if (a_valid_o !== 1'b1 || a_data_o !== 8'h0A) begin errors++; $display("FAIL fill_head i=%0d got v=%b d=%h exp 1 0a", i, a_valid_o, a_data_o); end
            end
            @(negedge clk);
        end
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", a_full); end
        checks++; if (a_ready_o !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", a_ready_o); end
        checks++; if (a_usage !== 2'd0) begin errors++; $display("FAIL fill_usage got %0d exp 0", a_usage); end
        for (int i = 0; i < 4; i++) begin
            a_ready_i = 1'b1;
            #1;
            checks++; if (a_valid_o !== 1'b1 || a_data_o !== 8'h0A + 8'(i)) begin errors++; $display("FAIL drain_data i=%0d got v=%b d=%h exp 1 %h", i, a_valid_o, a_data_o, 8'h0A + 8'(i)); end
            @(negedge clk);
        end
        a_ready_i = 1'b0;
        #1;
        checks++; if (a_empty !== 1'b1 || a_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%b valid=%b exp 1 0", a_empty, a_valid_o); end
    endtask

    task automatic test_fall_through();
        @(negedge clk);
        b_valid_i = 1'b1; b_data_i = 8'h55; b_ready_i = 1'b1;
        #1;
        checks++; if (b_valid_o !== 1'b1 || b_data_o !== 8'h55) begin errors++; $display("FAIL ft_bypass got v=%b d=%h exp 1 55", b_valid_o, b_data_o); end
        checks++; if (b_empty !== 1'b0) begin errors++; $display("FAIL ft_empty got %b exp 0", b_empty); end
        @(negedge clk);
        b_valid_i = 1'b0; b_ready_i = 1'b0;
        #1;
        checks++; if (b_empty !== 1'b1 || b_usage !== 2'd0) begin errors++; $display("FAIL ft_after got empty=%b usage=%0d exp 1 0", b_empty, b_usage); end
        b_valid_i = 1'b1; b_data_i = 8'h66;
        #1;
        checks++; if (b_data_o !== 8'h66) begin errors++; $display("FAIL ft_nopop_same got %h exp 66", b_data_o); end
        @(negedge clk);
        b_valid_i = 1'b0;
        #1;
        checks++; if (b_valid_o !== 1'b1 || b_data_o !== 8'h66 || b_usage !== 2'd1) begin errors++; $display("FAIL ft_stored got v=%b d=%h u=%0d exp 1 66 1", b_valid_o, b_data_o, b_usage); end
        b_ready_i = 1'b1;
        @(negedge clk);
        b_ready_i = 1'b0;
        #1;
        checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL ft_drained got %b exp 1", b_empty); end
    endtask

    task automatic test_full_push_pop();
        c_rst = 1'b1;
        @(negedge clk);
        c_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c_valid_i = 1'b1; c_data_i = 8'h10 + 8'(i);
            @(negedge clk);
        end
        c_valid_i = 1'b0;
        #1;
        checks++; if (c_full !== 1'b1 || c_usage !== 2'd3) begin errors++; $display("FAIL c_full got full=%b usage=%0d exp 1 3", c_full, c_usage); end
        for (int i = 0; i < 10; i++) begin
            c_valid_i = 1'b1; c_ready_i = 1'b1; c_data_i = 8'h13 + 8'(i);
            #1;
            checks++; if (c_data_o !== 8'h10 + 8'(i)) begin errors++; $display("FAIL c_stream i=%0d got %h exp %h", i, c_data_o, 8'h10 + 8'(i)); end
            @(negedge clk);
            c_valid_i = 1'b0; c_ready_i = 1'b0;
            #1;
            checks++; if (c_full !== 1'b1 || c_usage !== 2'd3) begin errors++; $display("FAIL c_stream_count i=%0d got full=%b usage=%0d exp 1 3", i, c_full, c_usage); end
        end
        for (int i = 0; i < 3; i++) begin
            c_ready_i = 1'b1;
            #1;
            checks++; if (c_data_o !== 8'h1A + 8'(i)) begin errors++; $display("FAIL c_drain i=%0d got %h exp %h", i, c_data_o, 8'h1A + 8'(i)); end
            @(negedge clk);
        end
        c_ready_i = 1'b0;
        #1;
        checks++; if (c_empty !== 1'b1) begin errors++; $display("FAIL c_drained got %b exp 1", c_empty); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            a_valid_i = 1'b1; a_data_i = 8'h21 + 8'(i);
            @(negedge clk);
        end
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_usage !== 2'd2) begin errors++; $display("FAIL flush_pre_usage got %0d exp 2", a_usage); end
        a_flush = 1'b1; a_valid_i = 1'b1; a_data_i = 8'h23;
        @(negedge clk);
        a_flush = 1'b0; a_valid_i = 1'b0;
        #1;
        checks++; if (a_empty !== 1'b1 || a_usage !== 2'd0) begin errors++; $display("FAIL flush_empty got empty=%b usage=%0d exp 1 0", a_empty, a_usage); end
        a_valid_i = 1'b1; a_data_i = 8'h31;
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_data_o !== 8'h31 || a_usage !== 2'd1) begin errors++; $display("FAIL flush_refill got d=%h u=%0d exp 31 1", a_data_o, a_usage); end
        a_ready_i = 1'b1;
        @(negedge clk);
        a_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            a_valid_i = 1'b1; a_data_i = 8'h41 + 8'(i);
            @(negedge clk);
        end
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_usage !== 2'd3) begin errors++; $display("FAIL rstmid_pre_usage got %0d exp 3", a_usage); end
        a_rst = 1'b1; a_flush = 1'b1; a_valid_i = 1'b1; a_ready_i = 1'b1;
        @(negedge clk);
        a_rst = 1'b0; a_flush = 1'b0; a_valid_i = 1'b0; a_ready_i = 1'b0;
        #1;
        checks++; if (a_valid_o !== 1'b0 || a_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_flags got valid=%b ready=%b exp 0 1", a_valid_o, a_ready_o); end
        checks++; if (a_usage !== 2'd0 || a_full !== 1'b0) begin errors++; $display("FAIL rstmid_usage got usage=%0d full=%b exp 0 0", a_usage, a_full); end
        a_ready_i = 1'b1;
        @(negedge clk);
        a_ready_i = 1'b0;
        #1;
        checks++; if (a_empty !== 1'b1 || a_usage !== 2'd0 || a_ready_o !== 1'b1) begin errors++; $display("FAIL pop_empty got empty=%b usage=%0d ready=%b exp 1 0 1", a_empty, a_usage, a_ready_o); end
        a_valid_i = 1'b1; a_data_i = 8'h44;
        @(negedge clk);
        a_valid_i = 1'b0;
        #1;
        checks++; if (a_data_o !== 8'h44 || a_usage !== 2'd1) begin errors++; $display("FAIL rstmid_refill got d=%h u=%0d exp 44 1", a_data_o, a_usage); end
    endtask

    task automatic test_passthrough();
        z_data_i = 8'h12; z_valid_i = 1'b1; z_ready_i = 1'b0;
        #1;
        checks++; if (z_data_o !== 8'h12 || z_valid_o !== 1'b1 || z_ready_o !== 1'b0) begin errors++; $display("FAIL pass_fixed got d=%h v=%b r=%b exp 12 1 0", z_data_o, z_valid_o, z_ready_o); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            logic       v, r;
            d = 8'($urandom); v = 1'($urandom); r = 1'($urandom);
            z_data_i = d; z_valid_i = v; z_ready_i = r;
            @(negedge clk);
            #1;
            checks++; if (z_data_o !== d || z_valid_o !== v || z_ready_o !== r) begin errors++; $display("FAIL pass_rand i=%0d got d=%h v=%b r=%b exp %h %b %b", i, z_data_o, z_valid_o, z_ready_o, d, v, r); end
        end
    endtask

    task automatic test_random();
        logic [7:0] qb[$];
        logic [7:0] qc[$];
        logic       eb, fb, ec, fc, popb, pushb, popc, pushc;
        logic [7:0] xb, xc;
        b_rst = 1'b1; c_rst = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            int unsigned rp;
            rp = (n / 50) % 4;
            b_rst = ($urandom_range(0, 79) == 0); c_rst = ($urandom_range(0, 79) == 0);
            if (n == 0) begin b_rst = 1'b0; c_rst = 1'b0; end
            b_flush = ($urandom_range(0, 39) == 0); c_flush = ($urandom_range(0, 39) == 0);
            b_valid_i = ($urandom_range(0, 3) >= rp); b_ready_i = ($urandom_range(0, 3) < rp + 1);
            c_valid_i = ($urandom_range(0, 3) >= rp); c_ready_i = ($urandom_range(0, 3) < rp + 1);
            b_data_i = 8'($urandom); c_data_i = 8'($urandom);
            #1;
            eb = (qb.size() == 0) && !b_valid_i;
            fb = (qb.size() == 4);
            xb = (qb.size() == 0) ? b_data_i : qb[0];
            ec = (qc.size() == 0);
            fc = (qc.size() == 3);
            xc = (qc.size() == 0) ? 8'h00 : qc[0];
            checks++; if (b_valid_o !== !eb || b_empty !== eb) begin errors++; $display("FAIL rand_b_valid n=%0d got v=%b e=%b exp v=%b", n, b_valid_o, b_empty, !eb); end
            checks++; if (b_full !== fb || b_ready_o !== !fb) begin errors++; $display("FAIL rand_b_full n=%0d got f=%b r=%b exp f=%b", n, b_full, b_ready_o, fb); end
            checks++; if (b_usage !== 2'(qb.size() % 4)) begin errors++; $display("FAIL rand_b_usage n=%0d got %0d exp %0d", n, b_usage, qb.size() % 4); end
            if (!eb) begin
                checks++; if (b_data_o !== xb) begin errors++; $display("FAIL rand_b_data n=%0d got %h exp %h", n, b_data_o, xb); end
            end
            checks++; if (c_valid_o !== !ec || c_empty !== ec) begin errors++; $display("FAIL rand_c_valid n=%0d got v=%b e=%b exp v=%b", n, c_valid_o, c_empty, !ec); end
            checks++; if (c_full !== fc || c_ready_o !== !fc) begin errors++; $display("FAIL rand_c_full n=%0d got f=%b r=%b exp f=%b", n, c_full, c_ready_o, fc); end
            checks++; if (c_usage !== 2'(qc.size())) begin errors++; $display("FAIL rand_c_usage n=%0d got %0d exp %0d", n, c_usage, qc.size()); end
            if (!ec) begin
                checks++; if (c_data_o !== xc) begin errors++; $display("FAIL rand_c_data n=%0d got %h exp %h", n, c_data_o, xc); end
            end
            if (b_rst || b_flush) begin
                qb.delete();
            end else begin
                popb  = b_ready_i && !eb;
                pushb = b_valid_i && (!fb || popb);
                if (!(qb.size() == 0 && pushb && popb)) begin
                    if (popb)  void'(qb.pop_front());
                    if (pushb) qb.push_back(b_data_i);
                end
            end
            if (c_rst || c_flush) begin
                qc.delete();
            end else begin
                popc  = c_ready_i && !ec;
                pushc = c_valid_i && (!fc || popc);
                if (popc)  void'(qc.pop_front());
                if (pushc) qc.push_back(c_data_i);
            end
            @(negedge clk);
        end
        b_rst = 1'b0; c_rst = 1'b0; b_flush = 1'b0; c_flush = 1'b0;
        b_valid_i = 1'b0; c_valid_i = 1'b0; b_ready_i = 1'b0; c_ready_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill_drain();
        test_fall_through();
        test_full_push_pop();
        test_flush();
        test_reset_mid();
        test_passthrough();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
